instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue_storage.sv | 29 ++
 rtl/instruction_fetch_queue.sv | 115 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared defaults and width derivations for the instruction fetch queue.
// The optional bypass path is controlled by the FETCH_QUEUE_BYPASS_EN macro in the top module.
package instruction_fetch_queue_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // DEPTH is a power of two, so a pointer of this width wraps modulo DEPTH by itself.
  function automatic int unsigned fq_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned fq_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register array,
// one synchronous write port and one asynchronous read port, never cleared.
module fetch_queue_storage
  import instruction_fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  parameter  int unsigned WIDTH = 2 * XLEN_DEFAULT,
  localparam int unsigned PTR_W = fq_ptr_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch-to-decode FIFO holding {PC, instruction} pairs with flush and synchronous reset.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass its input straight to decode.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  parameter  int unsigned XLEN  = XLEN_DEFAULT,
  localparam int unsigned PTR_W = fq_ptr_width(DEPTH),
  localparam int unsigned CNT_W = fq_cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_PC,
  input  logic [XLEN-1:0]  in_instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_PC,
  output logic [XLEN-1:0]  out_instruction,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [2*XLEN-1:0] head_s;
  logic              stored_valid_s;
  logic              bypass_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_en_s;

  // in_ready looks only at the stored count, so a full queue refuses even while popping.
  assign in_ready       = !reset && (count_q < CNT_W'(DEPTH));
  assign stored_valid_s = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_s = !stored_valid_s && in_valid && out_ready && !flush && !reset;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s  = in_valid && in_ready && !bypass_s;
  assign pop_s   = stored_valid_s && out_ready;
  assign wr_en_s = push_s && !flush;
  assign count   = count_q;

  fetch_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_storage (
    .CLK       (CLK),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({in_PC, in_instruction}),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_s)
  );

  // Head presentation: bypassed input, stored head entry, or zeros when empty
  always_comb begin
    out_valid       = 1'b0;
    out_PC          = '0;
    out_instruction = '0;
    if (bypass_s) begin
      out_valid       = 1'b1;
      out_PC          = in_PC;
      out_instruction = in_instruction;
    end else if (stored_valid_s) begin
      out_valid       = 1'b1;
      out_PC          = head_s[2*XLEN-1:XLEN];
      out_instruction = head_s[XLEN-1:0];
    end else begin
      out_valid       = 1'b0;
    end
  end

  // Pointer and count next state; reset and flush override any handshake
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge CLK) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: vector table plus scoreboard-checked sequences.
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_PC = 32'd0;
  logic [31:0] in_instruction = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_PC;
  logic [31:0] out_instruction;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  bit model_init = 1'b0;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [31:0] pc, ins;
    logic [2:0]  exp_cnt;
    logic        exp_ov;
    logic [31:0] exp_pc, exp_ins;
    logic        exp_ir;
  } vec_t;

  vec_t vecs[11];

  always #5 CLK = ~CLK;

  instruction_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_PC           (in_PC),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_PC          (out_PC),
    .out_instruction (out_instruction),
    .count           (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle; compare against the scoreboard before the edge, update it after.
  task automatic drive_cycle(input logic rst, input logic fl, input logic iv, input logic ordy,
                             input logic [31:0] pc, input logic [31:0] ins);
    bit byp, push, pop;
    logic [63:0] head;
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    in_PC = pc; in_instruction = ins;
    #1;
    byp  = BYP && (sb.size() == 0) && iv && ordy && !fl && !rst;
    push = iv && !rst && (sb.size() < DEPTH) && !byp;
    pop  = (sb.size() != 0) && ordy;
    head = (sb.size() != 0) ? sb[0] : 64'd0;
    if (model_init) begin
      chk("sb in_ready", {31'd0, in_ready}, {31'd0, (!rst && (sb.size() < DEPTH))});
      chk("sb out_valid", {31'd0, out_valid}, {31'd0, (byp || (sb.size() != 0))});
      chk("sb out_PC", out_PC, byp ? pc : head[63:32]);
      chk("sb out_instr", out_instruction, byp ? ins : head[31:0]);
      chk("sb count", {29'd0, count}, 32'(sb.size()));
    end
    @(posedge CLK);
    #1;
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({pc, ins});
    end
    if (rst) model_init = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
  endtask

  initial begin
    //          rst fl iv ordy pc           ins           cnt ov pc           ins           ir
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b0, 32'h0, 32'h0,        1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h00000013, 3'd1, 1'b1, 32'h0, 32'h00000013, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4,  32'h00500093, 3'd2, 1'b1, 32'h0, 32'h00000013, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        3'd1, 1'b1, 32'h4, 32'h00500093, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        3'd0, 1'b0, 32'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        3'd0, 1'b0, 32'h0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8,  32'h11111111, 3'd1, 1'b1, 32'h8, 32'h11111111, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hC,  32'h22222222, 3'd2, 1'b1, 32'h8, 32'h11111111, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        3'd0, 1'b0, 32'h0, 32'h0,        1'b1};

    @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].pc, vecs[i].ins);
      chk($sformatf("vec%0d count", i), {29'd0, count}, {29'd0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d out_PC", i), out_PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d out_instr", i), out_instruction, vecs[i].exp_ins);
      chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
    end

    // Fill to DEPTH, then a push while full but popping must be refused
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i));
    chk("full count", {29'd0, count}, 32'd4);
    chk("full in_ready", {31'd0, in_ready}, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h50, 32'hA0000004);
    chk("full push ignored count", {29'd0, count}, 32'd3);
    chk("after full in_ready", {31'd0, in_ready}, 32'd1);
    chk("after full head", out_PC, 32'h44);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("drained count", {29'd0, count}, 32'd0);

    // Continuous push+pop stream across several pointer wraps
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'hB000000F);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h10 + 32'(4 * i), 32'hB0000000 + 32'(i));
      chk($sformatf("stream%0d count", i), {29'd0, count}, 32'd1);
      chk($sformatf("stream%0d head", i), out_PC, 32'h10 + 32'(4 * i));
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("stream drained valid", {31'd0, out_valid}, 32'd0);

    // Flush with a simultaneous push: queue empties and the pushed entry is lost
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h60 + 32'(4 * i), 32'hC0000000 + 32'(i));
    chk("pre-flush count", {29'd0, count}, 32'd3);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("flush count", {29'd0, count}, 32'd0);
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("post-flush out_PC", out_PC, 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h00000013);
    chk("post-flush head", out_PC, 32'h200);
    chk("post-flush count", {29'd0, count}, 32'd1);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Empty queue, input and output handshake together: bypass or one-cycle latency
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_PC = 32'h20; in_instruction = 32'h00000013;
    #1;
    chk("bypass same-cycle valid", {31'd0, out_valid}, {31'd0, BYP});
    chk("bypass same-cycle PC", out_PC, BYP ? 32'h20 : 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h00000013);
    chk("latency count", {29'd0, count}, BYP ? 32'd0 : 32'd1);
    chk("latency out_PC", out_PC, BYP ? 32'h0 : 32'h20);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("final count", {29'd0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
